compare_iter: RTL

// - Parametrised, multi-cycle magnitude comparator; successor to the fixed 16-bit compare unit.
// - Compares A against B MSB-first, DIGIT bits per cycle. Reports greater (c), equal (z) and less (n).
// - Uses the cs/ready handshake plus a one-cycle done strobe. Sits beside the ALU, feeding branch/flag logic.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_digit.sv | 14 +
 rtl/compare_iter.sv | 119 +++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative magnitude comparator: FSM state
// encoding, flag-vector bit positions and counter sizing helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_BUSY = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_e;

  // Bit positions for consumers that bundle {c,z,n} into one flag vector.
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  function automatic int unsigned cnt_width(input int unsigned nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit unsigned compare; res = {a > b, a < b}.
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [1:0]       res
);

  always_comb begin
    res = {(a > b), (a < b)};
  end

endmodule

// File: rtl/compare_iter.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per BUSY cycle.
// Optional signed mode is enabled by defining CMP_SIGNED_EN.
module compare_iter
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic             c,
  output logic             z,
  output logic             n
);

  localparam int unsigned NSTEP = WIDTH / DIGIT;
  localparam int unsigned CW    = cnt_width(NSTEP);
  localparam logic [CW-1:0]    LAST = CW'(NSTEP - 1);
  localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             gt_q, lt_q;
  logic             gt_d, lt_d;
  logic [1:0]       dig_res;
  logic             sgn_eff;

`ifdef CMP_SIGNED_EN
  assign sgn_eff = sgn;
`else
  logic sgn_unused;
  assign sgn_unused = sgn;
  assign sgn_eff    = 1'b0;
`endif

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a   (a_q[WIDTH-1 -: DIGIT]),
    .b   (b_q[WIDTH-1 -: DIGIT]),
    .res (dig_res)
  );

  // First differing digit decides; later digits cannot override it.
  always_comb begin
    gt_d = gt_q | (~gt_q & ~lt_q & dig_res[1]);
    lt_d = lt_q | (~gt_q & ~lt_q & dig_res[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= CMP_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      CMP_IDLE: begin
        ready = 1'b1;
        if (cs) state_d = CMP_BUSY;
      end
      CMP_BUSY: begin
        if (cnt_q == LAST) state_d = CMP_DONE;
      end
      CMP_DONE: begin
        done    = 1'b1;
        state_d = CMP_IDLE;
      end
      default: state_d = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      c     <= 1'b0;
      z     <= 1'b0;
      n     <= 1'b0;
    end else begin
      case (state_q)
        CMP_IDLE: begin
          if (cs) begin
            // Flipping both sign bits maps two's-complement order onto unsigned order.
            a_q   <= A ^ (sgn_eff ? MSB : '0);
            b_q   <= B ^ (sgn_eff ? MSB : '0);
            cnt_q <= '0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
          end
        end
        CMP_BUSY: begin
          a_q   <= a_q << DIGIT;
          b_q   <= b_q << DIGIT;
          cnt_q <= cnt_q + 1'b1;
          gt_q  <= gt_d;
          lt_q  <= lt_d;
          if (cnt_q == LAST) begin
            c <= gt_d;
            n <= lt_d;
            z <= ~gt_d & ~lt_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
